// File: rtl/spram_pkg.sv
// Shared types and helpers for the byte-enable single-clock RAM.
package spram_pkg;

  // Init sequencer states: CLEAR zeroes the array, READY accepts traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } spram_state_e;

  // Same-address read-during-write result selection.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/spram_init_seq.sv
// Post-reset clear sequencer: walks clr_addr over every entry once, then
// parks in READY and raises init_done until the next reset.
module spram_init_seq
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_done,
  output spram_state_e          state
);

  localparam spram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  spram_state_e          state_q;
  spram_state_e          state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  init_done_q;

  // State register, clear counter and registered init_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == READY);
      if (state_q == CLEAR) begin
        clr_addr_q <= clr_addr_q + 1'b1;
      end
    end
  end

  // Next state: leave CLEAR once the last entry is being written.
  always_comb begin
    state_d = state_q;
    if ((state_q == CLEAR) && (clr_addr_q == {ADDR_WIDTH{1'b1}})) begin
      state_d = READY;
    end
  end

  // Outputs: clear write strobe follows the CLEAR state directly.
  always_comb begin
    clr_we    = (state_q == CLEAR);
    clr_addr  = clr_addr_q;
    init_done = init_done_q;
    state     = state_q;
  end

endmodule

// File: rtl/spram_be.sv
// Single-clock RAM, one write and one read port, per-byte write enables,
// read latency of 1 or 2, selectable read-during-write result and an
// optional zero-fill after reset.
//
// Handshake: there is no backpressure. A write is taken at every rising edge
// where wr_en=1 and init_done=1; a read is taken at every rising edge where
// rd_en=1 and init_done=1 and answered RD_LATENCY edges later by a one-cycle
// rd_valid strobe. Requests while init_done=0 are dropped.
module spram_be
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            wr_en,
  input  logic [ADDR_WIDTH-1:0]                           wr_ptr,
  input  logic [DATA_WIDTH-1:0]                           wr_data,
  input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]    wr_be,
  input  logic                                            rd_en,
  input  logic [ADDR_WIDTH-1:0]                           rd_ptr,
  output logic [DATA_WIDTH-1:0]                           rd_data,
  output logic                                            rd_valid,
  output logic                                            init_done
);

  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = depth(ADDR_WIDTH);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("spram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("spram_be: RD_LATENCY must be 1 or 2");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  spram_state_e          seq_state;
  logic                  accept;

  spram_init_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done),
    .state     (seq_state)
  );

  // Traffic is taken only once the sequencer is READY and init_done is up;
  // with no clear the two differ for the first cycle after reset release.
  assign accept = init_done && (seq_state == READY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_BYTES-1:0]  mem_we_lane;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic                  rd1_valid;

  // Write-port mux: clear sequencer owns the port during CLEAR.
  always_comb begin
    mem_we_lane = '0;
    mem_waddr   = wr_ptr;
    mem_wdata   = wr_data;
    if (clr_we) begin
      mem_we_lane = '1;
      mem_waddr   = clr_addr;
      mem_wdata   = '0;
    end else if (accept && wr_en) begin
      mem_we_lane = wr_be;
    end
  end

  // Array update, one lane per byte enable; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mem_we_lane[i]) begin
        mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_accept = accept && rd_en;

  // Read word: array holds pre-write data; optionally overlay enabled write lanes.
  always_comb begin
    rd_word = mem[rd_ptr];
    if ((RDW_MODE == RDW_NEW) && accept && wr_en && (rd_ptr == wr_ptr)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // First read stage: data holds between reads, valid is a per-read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd1_valid <= rd_accept;
      if (rd_accept) begin
        rd1_data <= rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd2_data;
    logic                  rd2_valid;

    // Second read stage: same hold/strobe behaviour, one cycle later.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd2_data  <= '0;
        rd2_valid <= 1'b0;
      end else begin
        rd2_valid <= rd1_valid;
        if (rd1_valid) begin
          rd2_data <= rd1_data;
        end
      end
    end

    assign rd_data  = rd2_data;
    assign rd_valid = rd2_valid;
  end else begin : g_lat1
    assign rd_data  = rd1_data;
    assign rd_valid = rd1_valid;
  end

endmodule

// File: tb/tb_spram_be.sv
// Directed bench for spram_be. Three configurations share one stimulus:
//   dut_a: latency 1, old-data RDW, clear on reset
//   dut_b: latency 2, new-data RDW, clear on reset
//   dut_c: latency 1, old-data RDW, no clear
module tb_spram_be;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_ptr  = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_be   = '0;
  logic          rd_en   = 1'b0;
  logic [AW-1:0] rd_ptr  = '0;

  logic [DW-1:0] rd_data_a, rd_data_b, rd_data_c;
  logic          rd_valid_a, rd_valid_b, rd_valid_c;
  logic          init_done_a, init_done_b, init_done_c;

  spram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
             .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .init_done(init_done_a));

  spram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
             .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .init_done(init_done_b));

  spram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
             .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_data(rd_data_c),
    .rd_valid(rd_valid_c), .init_done(init_done_c));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Read data of every rd_valid strobe is matched against the queue in order.
  always @(negedge clk) begin
    if (!rst && rd_valid_a) begin
      if (exp_a_q.size() == 0) check_val("a_spurious_valid", 32'd1, 32'd0);
      else check_val("a_rd_data", rd_data_a, exp_a_q.pop_front());
    end
    if (!rst && rd_valid_b) begin
      if (exp_b_q.size() == 0) check_val("b_spurious_valid", 32'd1, 32'd0);
      else check_val("b_rd_data", rd_data_b, exp_b_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [AW-1:0] addr, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    rd_en  = 1'b1;
    rd_ptr = addr;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [NB-1:0] be);
    wr_en   = 1'b1;
    wr_ptr  = addr;
    wr_data = data;
    wr_be   = be;
    tick();
    wr_en   = 1'b0;
  endtask

  // Single isolated read; checks strobe timing of both latencies.
  task automatic read_one(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    rd_issue(addr, exp, exp);
    tick();
    rd_en = 1'b0;
    check_val("a_valid_lat1", rd_valid_a, 1'b1);
    check_val("b_valid_early", rd_valid_b, 1'b0);
    check_val("c_valid_lat1", rd_valid_c, 1'b1);
    tick();
    check_val("a_valid_drop", rd_valid_a, 1'b0);
    check_val("b_valid_lat2", rd_valid_b, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset state
    tick();
    tick();
    check_val("rst_rd_data_a", rd_data_a, 32'h0);
    check_val("rst_rd_valid_a", rd_valid_a, 1'b0);
    check_val("rst_init_done_a", init_done_a, 1'b0);
    check_val("rst_init_done_c", init_done_c, 1'b0);
    check_val("rst_rd_data_b", rd_data_b, 32'h0);
    rst = 1'b0;

    // No-clear configuration is ready one edge after release.
    tick();
    check_val("c_init_first_edge", init_done_c, 1'b1);
    check_val("a_init_first_edge", init_done_a, 1'b0);

    // Reset mid-clear at clear cycle 7.
    for (int i = 0; i < 6; i++) tick();
    check_val("a_init_mid_clear", init_done_a, 1'b0);
    rst = 1'b1;
    tick();
    check_val("a_init_in_reset", init_done_a, 1'b0);
    rst = 1'b0;

    // Clear restarts from 0; write/read pulsed during clear must be ignored.
    n = 0;
    while (!init_done_a && n < 40) begin
      tick();
      n++;
      if (n == 9) begin
        wr_en = 1'b1; wr_ptr = 4'd2; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_ptr = 4'd2;
      end else if (n == 10) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_val("a_no_valid_in_clear", rd_valid_a, 1'b0);
      end
    end
    check_val("clear_cycles_a", n, 32'd16);
    check_val("b_init_done", init_done_b, 1'b1);

    // All entries read back as zero.
    for (int i = 0; i < 16; i++) read_one(i[AW-1:0], 32'h0);

    // Byte-enable merge.
    write_word(4'd3, 32'hAABB_CCDD, 4'b1111);
    write_word(4'd3, 32'h1122_3344, 4'b0101);
    read_one(4'd3, 32'hAA22_CC44);

    // Back-to-back reads, both latencies.
    write_word(4'd0, 32'h10, 4'hF);
    write_word(4'd1, 32'h11, 4'hF);
    write_word(4'd2, 32'h12, 4'hF);
    rd_issue(4'd0, 32'h10, 32'h10);
    tick();
    check_val("bb_a_v0", rd_valid_a, 1'b1);
    check_val("bb_b_v0", rd_valid_b, 1'b0);
    rd_issue(4'd1, 32'h11, 32'h11);
    tick();
    check_val("bb_a_v1", rd_valid_a, 1'b1);
    check_val("bb_b_v1", rd_valid_b, 1'b1);
    rd_issue(4'd2, 32'h12, 32'h12);
    tick();
    rd_en = 1'b0;
    check_val("bb_a_v2", rd_valid_a, 1'b1);
    check_val("bb_b_v2", rd_valid_b, 1'b1);
    tick();
    check_val("bb_a_v3", rd_valid_a, 1'b0);
    check_val("bb_b_v3", rd_valid_b, 1'b1);
    tick();
    check_val("bb_b_v4", rd_valid_b, 1'b0);

    // Same-address read-during-write: a returns old, b returns merged.
    wr_en = 1'b1; wr_ptr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'b0011;
    rd_issue(4'd5, 32'h0000_0000, 32'h0000_BEEF);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_val("rdw_a_valid", rd_valid_a, 1'b1);
    tick();
    check_val("rdw_b_valid", rd_valid_b, 1'b1);
    read_one(4'd5, 32'h0000_BEEF);

    // Different addresses in the same edge are independent.
    wr_en = 1'b1; wr_ptr = 4'd6; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_issue(4'd4, 32'h0, 32'h0);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    read_one(4'd6, 32'hFFFF_FFFF);

    // Idle hold: rd_data keeps last value while other addresses are written.
    write_word(4'd7, 32'h1234_5678, 4'hF);
    read_one(4'd7, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_ptr = 4'd8 + k[AW-1:0]; wr_data = 32'hCAFE_0000 + k; wr_be = 4'hF;
      tick();
      check_val("hold_a_data", rd_data_a, 32'h1234_5678);
      check_val("hold_a_valid", rd_valid_a, 1'b0);
      check_val("hold_b_data", rd_data_b, 32'h1234_5678);
      check_val("hold_b_valid", rd_valid_b, 1'b0);
      check_val("hold_c_data", rd_data_c, 32'h1234_5678);
    end
    wr_en = 1'b0;

    tick();
    tick();
    check_val("a_queue_drained", exp_a_q.size(), 32'd0);
    check_val("b_queue_drained", exp_b_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spram_be.md
Name: spram_be

Overview:
- Next-generation single-clock memory with 1 write port and 1 read port. Adds per-byte write enables, a selectable read latency (1 or 2), a defined read-during-write result, a read-valid strobe, and an optional post-reset clear sequencer.
- Used as the storage primitive under the MMU tables and buffers wherever deterministic power-up contents or partial-word updates are needed.

Parameters:
- ADDR_WIDTH, 6: address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 64: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1: cycles from accepted rd_en to rd_data/rd_valid; legal values are 1 and 2.
- RDW_MODE, 0: same-address read-during-write result. 0 = old data; 1 = new data, byte-merged.
- CLEAR_ON_RESET, 1: 1 = zero every entry after reset before accepting traffic.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_ptr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  NUM_BYTES  byte enables; bit i controls bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_ptr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; holds its last value between reads.
- rd_valid  out  1  one-cycle strobe marking new rd_data.
- init_done  out  1  high once the block accepts traffic.

Behaviour:
- Reset (async assert, sync release):
  - rd_data=0, rd_valid=0, init_done=0, pipeline stages and clear counter cleared.
  - Memory array contents are not reset.
- FSM states: CLEAR, READY. Reset enters CLEAR when CLEAR_ON_RESET=1, else READY.
- CLEAR:
  - Counter clr_addr runs 0..DEPTH-1, one entry per cycle. Each entry is written with 0 on all lanes.
  - After writing DEPTH-1, the FSM moves to READY. Clear takes exactly DEPTH cycles after reset release.
  - wr_en and rd_en are ignored (no write, no rd_valid).
  - Reset asserted mid-clear restarts the clear from address 0.
- READY:
  - init_done=1, registered; it rises the cycle the FSM enters READY.
  - With CLEAR_ON_RESET=0, init_done rises on the first clock edge after reset release.
  - Stays in READY until the next reset.
- Write: at the clock edge with wr_en=1, each lane with wr_be[i]=1 takes wr_data; other lanes keep their contents. wr_be=0 with wr_en=1 is a legal no-op.
- Read:
  - rd_en=1 at edge N captures the entry.
  - RD_LATENCY=1: rd_data updates and rd_valid=1 after edge N.
  - RD_LATENCY=2: data passes through a second register; rd_data/rd_valid appear after edge N+1.
  - Back-to-back reads sustain 1 per cycle at either latency.
  - rd_valid is low in every cycle with no matching read.
- Read-during-write, rd_en & wr_en, rd_ptr==wr_ptr, same edge:
  - RDW_MODE=0: returns pre-write contents.
  - RDW_MODE=1: returns wr_data on enabled lanes and old contents on disabled lanes.
  - With different addresses the two ports are independent.
- Address wrap: pointers are exactly ADDR_WIDTH bits, so there are no out-of-range accesses.
- Elaboration must fail if DATA_WIDTH % BYTE_WIDTH != 0 or RD_LATENCY is not 1 or 2.

Decomposition:
- Shared package spram_pkg holds:
  - state enum {CLEAR, READY};
  - RDW_OLD=0 and RDW_NEW=1 constants;
  - helper functions for NUM_BYTES and DEPTH.
- Sub-module spram_init_seq: the CLEAR/READY FSM plus clr_addr counter. Outputs clr_we, clr_addr and init_done; the top level muxes these onto the write port.
- The memory array, byte merge and read pipeline stay in spram_be.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8 unless noted):
1. Clear sequence: release rst with CLEAR_ON_RESET=1 -> init_done low for 16 cycles then high. Reads of all 16 addresses return 0x00000000, each with rd_valid one cycle after rd_en.
2. Byte-enable write: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read addr 3 returns 0xAA22CC44.
3. Latency/throughput, RD_LATENCY=2: reads of addrs 0,1,2 on consecutive cycles, holding 0x10,0x11,0x12 -> rd_valid high for 3 consecutive cycles starting 2 edges after the first rd_en; data 0x10,0x11,0x12 in order.
4. Read-during-write: addr 5 holds 0x00000000; same edge write 0xDEADBEEF be=4'b0011 and read addr 5 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000BEEF.
5. Reset mid-clear: assert rst at clear cycle 7, release -> clear restarts at addr 0 and init_done rises 16 cycles after release. wr_en pulsed during clear has no effect: addr 2 still reads 0.
6. Idle hold: after a read returning 0x12345678, hold rd_en=0 for 5 cycles while writing other addresses -> rd_data stays 0x12345678 and rd_valid stays 0.
